// File: rtl/popcount_pkg.sv
// Shared types and width helpers for the streaming popcount accumulator.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package popcount_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    return $clog2(value);
  endfunction

  // Result width: enough bits for every bit of a full-length vector being set.
  function automatic int cnt_w(input int width, input int max_beats);
    return clog2(width * max_beats + 1);
  endfunction

  // Beat counter has to be able to hold MAX_BEATS itself.
  function automatic int beat_cnt_w(input int max_beats);
    return clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/popcount_tree.sv
// Exact combinational popcount built as a recursive tree of half/full adders.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
module popcount_tree
  import popcount_pkg::*;
#(
  parameter int WIDTH = 22,
  localparam int OUT_W = clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] in_bits,
  output logic [OUT_W-1:0] out_cnt
);

  // Leaves are single bits, half adders or full adders; larger inputs split
  // in two and the partial counts are summed, giving a balanced tree.
  generate
    if (WIDTH == 1) begin : g_leaf1
      assign out_cnt = in_bits;
    end else if (WIDTH == 2) begin : g_half_add
      assign out_cnt = {in_bits[1] & in_bits[0], in_bits[1] ^ in_bits[0]};
    end else if (WIDTH == 3) begin : g_full_add
      assign out_cnt = {(in_bits[0] & in_bits[1]) | (in_bits[2] & (in_bits[0] ^ in_bits[1])),
                        in_bits[0] ^ in_bits[1] ^ in_bits[2]};
    end else begin : g_split
      localparam int LO_W  = WIDTH / 2;
      localparam int HI_W  = WIDTH - LO_W;
      localparam int LO_CW = clog2(LO_W + 1);
      localparam int HI_CW = clog2(HI_W + 1);
      logic [LO_CW-1:0] lo_cnt;
      logic [HI_CW-1:0] hi_cnt;

      popcount_tree #(.WIDTH(LO_W)) u_lo (
        .in_bits (in_bits[LO_W-1:0]),
        .out_cnt (lo_cnt)
      );
      popcount_tree #(.WIDTH(HI_W)) u_hi (
        .in_bits (in_bits[WIDTH-1:LO_W]),
        .out_cnt (hi_cnt)
      );

      assign out_cnt = OUT_W'(lo_cnt) + OUT_W'(hi_cnt);
    end
  endgenerate

endmodule

// File: rtl/popcount_stream_acc.sv
// Accumulates popcount over a multi-beat vector (exact or LSB-truncated) and reports count + fire bit.
// Latency: result valid the cycle after the last beat is accepted; all outputs registered.
// Backpressure: in_ready drops while a result is held; released the cycle after out handshake.
module popcount_stream_acc
  import popcount_pkg::*;
#(
  parameter int WIDTH        = 22,
  parameter int MAX_BEATS    = 4,
  parameter int APPROX_SHIFT = 1,
  localparam int CNT_W       = cnt_w(WIDTH, MAX_BEATS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_approx,
  input  logic [CNT_W-1:0] in_thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_fire,
  output logic             out_trunc
);

  localparam int PC_W = clog2(WIDTH + 1);
  localparam int BC_W = beat_cnt_w(MAX_BEATS);

  state_t           state_q,     state_d;
  logic [CNT_W-1:0] acc_q,       acc_d;
  logic [BC_W-1:0]  beat_cnt_q,  beat_cnt_d;
  logic             approx_q,    approx_d;
  logic [CNT_W-1:0] thresh_q,    thresh_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_fire_q,  out_fire_d;
  logic             out_trunc_q, out_trunc_d;

  logic [PC_W-1:0]  pc;
  logic             first_beat;
  logic             mode;
  logic [CNT_W-1:0] thresh_eff;
  logic [CNT_W-1:0] term;
  logic [CNT_W-1:0] acc_sum;
  logic [BC_W-1:0]  beat_inc;
  logic             reached_max;

  popcount_tree #(.WIDTH(WIDTH)) u_tree (
    .in_bits (in_data),
    .out_cnt (pc)
  );

  // Per-beat term and running sums; the first beat uses live mode/threshold
  // because they are only being latched on that same edge.
  always_comb begin
    first_beat  = (state_q == IDLE);
    mode        = first_beat ? in_approx : approx_q;
    thresh_eff  = first_beat ? in_thresh : thresh_q;
    term        = mode ? ((CNT_W'(pc) >> APPROX_SHIFT) << APPROX_SHIFT) : CNT_W'(pc);
    acc_sum     = (first_beat ? '0 : acc_q) + term;
    beat_inc    = (first_beat ? '0 : beat_cnt_q) + BC_W'(1);
    reached_max = (beat_inc == BC_W'(MAX_BEATS));
  end

  // Next-state, accumulator and result capture.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    beat_cnt_d  = beat_cnt_q;
    approx_d    = approx_q;
    thresh_d    = thresh_q;
    out_count_d = out_count_q;
    out_fire_d  = out_fire_q;
    out_trunc_d = out_trunc_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (in_valid) begin
          acc_d      = acc_sum;
          beat_cnt_d = beat_inc;
          if (first_beat) begin
            approx_d = in_approx;
            thresh_d = in_thresh;
          end
          if (in_last || reached_max) begin
            state_d     = DONE;
            out_count_d = acc_sum;
            out_fire_d  = (acc_sum >= thresh_eff);
            out_trunc_d = reached_max && !in_last;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d    = IDLE;
          acc_d      = '0;
          beat_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial vector or pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      beat_cnt_q  <= '0;
      approx_q    <= 1'b0;
      thresh_q    <= '0;
      out_count_q <= '0;
      out_fire_q  <= 1'b0;
      out_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beat_cnt_q  <= beat_cnt_d;
      approx_q    <= approx_d;
      thresh_q    <= thresh_d;
      out_count_q <= out_count_d;
      out_fire_q  <= out_fire_d;
      out_trunc_q <= out_trunc_d;
    end
  end

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign out_count = out_count_q;
  assign out_fire  = out_fire_q;
  assign out_trunc = out_trunc_q;

endmodule

// File: tb/tb_popcount_stream_acc.sv
// Directed plus randomized bench for popcount_stream_acc at default parameters.
// Latency: checks result visible the cycle after the last beat is accepted.
// Backpressure: exercises held results, stalled beats and reset in every state.
module tb_popcount_stream_acc;

  localparam int SHIFT = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [21:0] in_data;
  logic        in_last;
  logic        in_approx;
  logic [6:0]  in_thresh;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_count;
  logic        out_fire;
  logic        out_trunc;

  int n_checks = 0;
  int n_pass   = 0;

  popcount_stream_acc #(.WIDTH(22), .MAX_BEATS(4), .APPROX_SHIFT(SHIFT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_approx (in_approx),
    .in_thresh (in_thresh),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_fire  (out_fire),
    .out_trunc (out_trunc)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d passed=%0d", n_checks, n_pass);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: each beat contributes its bit count, rounded down to a multiple
  // of 2**SHIFT in approximate mode.
  function automatic int term_of(input logic [21:0] d, input bit ap);
    int pc;
    pc = $countones(d);
    return ap ? (pc - (pc % (1 << SHIFT))) : pc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until the DUT takes it; returns one cycle after acceptance.
  task automatic send_beat(input logic [21:0] d, input logic last, input logic ap, input logic [6:0] th);
    int t;
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = last;
    in_approx = ap;
    in_thresh = th;
    t = 0;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    if (!in_ready) check("accept_timeout", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Result must already be visible; optionally hold it, then handshake.
  task automatic expect_result(input string tag, input int cnt, input bit fire, input bit trunc, input int hold);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_count"}, {25'd0, out_count}, cnt);
    check({tag, "_fire"},  {31'd0, out_fire},  {31'd0, fire});
    check({tag, "_trunc"}, {31'd0, out_trunc}, {31'd0, trunc});
    repeat (hold) tick();
    if (hold > 0) check({tag, "_held_count"}, {25'd0, out_count}, cnt);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_clr"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_rdy_back"},  {31'd0, in_ready},  32'd1);
  endtask

  initial begin
    int nb;
    bit lastf;
    bit ap0;
    logic [6:0] th;
    int sum;
    logic [21:0] d;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_approx = 1'b0;
    in_thresh = '0;
    out_ready = 1'b0;
    repeat (2) tick();

    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_count", {25'd0, out_count}, 32'd0);
    check("rst_out_fire",  {31'd0, out_fire},  32'd0);
    check("rst_out_trunc", {31'd0, out_trunc}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single full beat, exact.
    send_beat(22'h3FFFFF, 1'b1, 1'b0, 7'd22);
    expect_result("single", 22, 1'b1, 1'b0, 0);

    // Three beats, exact, then approx, then exact with mode/threshold noise on later beats.
    send_beat(22'h000001, 1'b0, 1'b0, 7'd5);
    send_beat(22'h000003, 1'b0, 1'b1, 7'd127);
    send_beat(22'h000007, 1'b1, 1'b1, 7'd127);
    expect_result("exact3", 6, 1'b1, 1'b0, 0);
    send_beat(22'h000001, 1'b0, 1'b1, 7'd5);
    send_beat(22'h000003, 1'b0, 1'b0, 7'd0);
    send_beat(22'h000007, 1'b1, 1'b0, 7'd0);
    expect_result("approx3", 4, 1'b0, 1'b0, 0);
    send_beat(22'h000001, 1'b0, 1'b0, 7'd5);
    send_beat(22'h000003, 1'b0, 1'b1, 7'd0);
    tick();
    send_beat(22'h000007, 1'b1, 1'b1, 7'd0);
    expect_result("exact3_tog", 6, 1'b1, 1'b0, 0);

    // Force-terminated vector; fifth beat stalls under a held result.
    for (int i = 0; i < 4; i++) send_beat(22'h00000F, 1'b0, 1'b0, 7'd0);
    check("trunc_valid", {31'd0, out_valid}, 32'd1);
    check("trunc_count", {25'd0, out_count}, 32'd16);
    check("trunc_flag",  {31'd0, out_trunc}, 32'd1);
    in_valid = 1'b1;
    in_data  = 22'h00000F;
    in_last  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_valid",    {31'd0, out_valid}, 32'd1);
      check("stall_count",    {25'd0, out_count}, 32'd16);
      check("stall_fire",     {31'd0, out_fire},  32'd1);
      check("stall_in_ready", {31'd0, in_ready},  32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hs_valid_clr", {31'd0, out_valid}, 32'd0);
    check("hs_in_ready",  {31'd0, in_ready},  32'd1);
    send_beat(22'h00000F, 1'b0, 1'b0, 7'd0);
    send_beat(22'h000000, 1'b1, 1'b0, 7'd0);
    expect_result("carried_beat", 4, 1'b1, 1'b0, 0);

    // Asynchronous reset mid-vector.
    send_beat(22'h3FFFFF, 1'b0, 1'b0, 7'd0);
    send_beat(22'h3FFFFF, 1'b0, 1'b0, 7'd0);
    rst_n = 1'b0;
    #1;
    check("arst_acc_in_ready",  {31'd0, in_ready},  32'd1);
    check("arst_acc_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_acc_out_count", {25'd0, out_count}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send_beat(22'h000005, 1'b1, 1'b0, 7'd0);
    expect_result("post_rst", 2, 1'b1, 1'b0, 0);

    // Asynchronous reset while a result is pending.
    send_beat(22'h3FFFFF, 1'b1, 1'b0, 7'd0);
    check("pre_rst_done_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_done_valid", {31'd0, out_valid}, 32'd0);
    check("arst_done_count", {25'd0, out_count}, 32'd0);
    check("arst_done_fire",  {31'd0, out_fire},  32'd0);
    check("arst_done_ready", {31'd0, in_ready},  32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // Threshold boundaries.
    send_beat(22'h0001FF, 1'b1, 1'b0, 7'd10);
    expect_result("thr_below", 9, 1'b0, 1'b0, 3);
    send_beat(22'h0003FF, 1'b1, 1'b0, 7'd10);
    expect_result("thr_equal", 10, 1'b1, 1'b0, 0);
    send_beat(22'h000000, 1'b1, 1'b0, 7'd0);
    expect_result("thr_zero", 0, 1'b1, 1'b0, 0);

    // Randomized vectors against the reference model.
    for (int v = 0; v < 40; v++) begin
      nb    = $urandom_range(1, 4);
      lastf = (nb < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      ap0   = 1'($urandom_range(0, 1));
      th    = 7'($urandom_range(0, 88));
      sum   = 0;
      for (int b = 0; b < nb; b++) begin
        d = 22'($urandom);
        sum += term_of(d, ap0);
        send_beat(d, (b == nb - 1) && lastf,
                  (b == 0) ? ap0 : 1'($urandom_range(0, 1)),
                  (b == 0) ? th : 7'($urandom));
        if (b != nb - 1) repeat ($urandom_range(0, 2)) tick();
      end
      expect_result("rand", sum, (sum >= int'(th)), (nb == 4) && !lastf, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
